// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter that feeds the SDRAM controller.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int unsigned WDT_W = 16;

    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ST_GRANT0: g = GRANT_M0;
            ST_GRANT1: g = GRANT_M1;
            default:   g = GRANT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Stall watchdog: counts consecutive stalled beats and flags the TIMEOUT-th one.
module sdram_arb_watchdog
    import sdram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam logic [WDT_W-1:0] LIMIT = WDT_W'(TIMEOUT - 1);

    logic [WDT_W-1:0] cnt_q;
    logic [WDT_W-1:0] cnt_d;

    // Next count: clear wins over increment; saturates because the grant is dropped on expiry anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + WDT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q already holds TIMEOUT-1 earlier stalls, so this stalled cycle is the TIMEOUT-th.
    assign expired_o = en_i && !clr_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter with alternating priority and a stall watchdog toward the SDRAM controller.
module sdram_wb_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 22,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    input  logic              m0_we_i,
    input  logic              m0_stb_i,
    input  logic              m0_cyc_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    input  logic              m1_we_i,
    input  logic              m1_stb_i,
    input  logic              m1_cyc_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_dat_o,
    output logic              s_we_o,
    output logic              s_stb_o,
    output logic              s_cyc_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_grant_q;
    logic       last_grant_d;
    logic [1:0] grant_q;
    logic [1:0] grant_d;

    logic granted_s;
    logic sel_stb_s;
    logic wd_en_s;
    logic wd_clr_s;
    logic wd_expired_s;

    // Watchdog qualifiers for the currently granted master.
    always_comb begin
        granted_s = 1'b0;
        sel_stb_s = 1'b0;
        case (state_q)
            ST_GRANT0: begin
                granted_s = 1'b1;
                sel_stb_s = m0_stb_i;
            end
            ST_GRANT1: begin
                granted_s = 1'b1;
                sel_stb_s = m1_stb_i;
            end
            default: begin
                granted_s = 1'b0;
                sel_stb_s = 1'b0;
            end
        endcase
        wd_en_s  = granted_s && sel_stb_s && !s_ack_i;
        wd_clr_s = !granted_s || !sel_stb_s || s_ack_i;
    end

    sdram_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (wd_en_s),
        .clr_i     (wd_clr_s),
        .expired_o (wd_expired_s)
    );

    // Next-state: last_grant holds the index of the most recent owner (0 = m0, 1 = m1).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_grant_q) begin
                        state_d      = ST_GRANT0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = ST_GRANT1;
                        last_grant_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d      = ST_GRANT0;
                    last_grant_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = ST_GRANT1;
                    last_grant_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                if (wd_expired_s || !m0_cyc_i) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b0;
                end else begin
                    state_d = ST_GRANT0;
                end
            end
            ST_GRANT1: begin
                if (wd_expired_s || !m1_cyc_i) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b1;
                end else begin
                    state_d = ST_GRANT1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        grant_d = grant_of(state_d);
    end

    // State, priority and grant registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= GRANT_NONE;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    // Slave-side mux and ack/err routing; an expiring beat is withdrawn from the slave.
    always_comb begin
        s_addr_o = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            ST_GRANT0: begin
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_stb_o  = m0_stb_i && !wd_expired_s;
                s_cyc_o  = m0_cyc_i && !wd_expired_s;
                m0_ack_o = s_ack_i;
                m0_err_o = wd_expired_s;
            end
            ST_GRANT1: begin
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_stb_o  = m1_stb_i && !wd_expired_s;
                s_cyc_o  = m1_cyc_i && !wd_expired_s;
                m1_ack_o = s_ack_i;
                m1_err_o = wd_expired_s;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = grant_q;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level arbiter model.
module tb_sdram_wb_arbiter;

    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk_i   = 1'b0;
    logic              rst_n_i = 1'b1;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i, s_addr_o;
    logic [DATA_W-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic              m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
    logic              m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
    logic              s_we_o, s_stb_o, s_cyc_o, s_ack_i;
    logic [1:0]        grant_o;

    int tests = 0;
    int fails = 0;

    // Model: who owns the bus (-1 none), who owned it last, consecutive stalled beats so far.
    int owner;
    int last;
    int stall;
    logic abort;

    always #5 clk_i = ~clk_i;

    sdram_wb_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .m0_addr_i (m0_addr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_we_i   (m0_we_i),
        .m0_stb_i  (m0_stb_i),
        .m0_cyc_i  (m0_cyc_i),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_addr_i (m1_addr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_we_i   (m1_we_i),
        .m1_stb_i  (m1_stb_i),
        .m1_cyc_i  (m1_cyc_i),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_addr_o  (s_addr_o),
        .s_dat_o   (s_dat_o),
        .s_we_o    (s_we_o),
        .s_stb_o   (s_stb_o),
        .s_cyc_o   (s_cyc_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .grant_o   (grant_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_addr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
        m1_addr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
        s_dat_i   = '0; s_ack_i  = 1'b0;
    endtask

    task automatic model_reset();
        owner = -1;
        last  = 1;
        stall = 0;
    endtask

    // Compare every output against the model for the current cycle's inputs.
    task automatic sample();
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_dat;
        logic e_we, e_stb, e_cyc, e_ack0, e_ack1, e_err0, e_err1;
        logic [1:0] e_grant;
        #2;
        e_addr = '0; e_dat = '0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0;
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
        e_grant = 2'b00;
        abort = 1'b0;
        if (owner == 0) begin
            abort  = m0_stb_i && !s_ack_i && (stall == TIMEOUT - 1);
            e_addr = m0_addr_i; e_dat = m0_dat_i; e_we = m0_we_i;
            e_stb  = m0_stb_i && !abort;
            e_cyc  = m0_cyc_i && !abort;
            e_ack0 = s_ack_i && !abort;
            e_err0 = abort;
            e_grant = 2'b01;
        end else if (owner == 1) begin
            abort  = m1_stb_i && !s_ack_i && (stall == TIMEOUT - 1);
            e_addr = m1_addr_i; e_dat = m1_dat_i; e_we = m1_we_i;
            e_stb  = m1_stb_i && !abort;
            e_cyc  = m1_cyc_i && !abort;
            e_ack1 = s_ack_i && !abort;
            e_err1 = abort;
            e_grant = 2'b10;
        end
        chk("s_cyc",  64'(s_cyc_o),  64'(e_cyc));
        chk("s_stb",  64'(s_stb_o),  64'(e_stb));
        chk("s_we",   64'(s_we_o),   64'(e_we));
        chk("s_addr", 64'(s_addr_o), 64'(e_addr));
        chk("s_dat",  64'(s_dat_o),  64'(e_dat));
        chk("m0_ack", 64'(m0_ack_o), 64'(e_ack0));
        chk("m1_ack", 64'(m1_ack_o), 64'(e_ack1));
        chk("m0_err", 64'(m0_err_o), 64'(e_err0));
        chk("m1_err", 64'(m1_err_o), 64'(e_err1));
        chk("grant",  64'(grant_o),  64'(e_grant));
        chk("m0_dat", 64'(m0_dat_o), 64'(s_dat_i));
        chk("m1_dat", 64'(m1_dat_o), 64'(s_dat_i));
    endtask

    // Apply the arbitration rules for the coming clock edge, then move to the next drive point.
    task automatic advance();
        logic cyc_x, stb_x;
        if (!rst_n_i) begin
            model_reset();
        end else if (owner < 0) begin
            if (m0_cyc_i && m1_cyc_i) owner = 1 - last;
            else if (m0_cyc_i)        owner = 0;
            else if (m1_cyc_i)        owner = 1;
            if (owner >= 0) last = owner;
            stall = 0;
        end else begin
            cyc_x = (owner == 0) ? m0_cyc_i : m1_cyc_i;
            stb_x = (owner == 0) ? m0_stb_i : m1_stb_i;
            if (abort || !cyc_x) begin
                owner = -1;
                stall = 0;
            end else if (stb_x && !s_ack_i) begin
                stall++;
            end else begin
                stall = 0;
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1 rst_n_i = 1'b0;
        sample(); chk("rst_grant", 64'(grant_o), 64'h0); advance();
        sample(); advance();
        rst_n_i = 1'b1;
        sample(); advance();

        // Contention from reset: m0, one idle cycle, m1, then m0 again.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        sample(); advance();
        sample(); chk("c_first", 64'(grant_o), 64'h1); advance();
        s_ack_i = 1'b1;
        sample(); chk("c_m0ack", 64'(m0_ack_o), 64'h1); chk("c_m1ack", 64'(m1_ack_o), 64'h0); advance();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        sample(); advance();
        sample(); chk("c_gap", 64'(grant_o), 64'h0); advance();
        sample(); chk("c_second", 64'(grant_o), 64'h2); advance();
        s_ack_i = 1'b1;
        sample(); chk("c_m1ack2", 64'(m1_ack_o), 64'h1); advance();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        sample(); advance();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        sample(); advance();
        sample(); chk("c_third", 64'(grant_o), 64'h1); advance();
        idle_inputs();
        sample(); advance();
        sample(); advance();

        // m0 single write.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_addr_i = 22'h000010; m0_dat_i = 32'hDEADBEEF;
        sample(); chk("w_lat0", 64'(s_cyc_o), 64'h0); advance();
        sample();
        chk("w_cyc", 64'(s_cyc_o), 64'h1);
        chk("w_addr", 64'(s_addr_o), 64'h10);
        chk("w_dat", 64'(s_dat_o), 64'hDEADBEEF);
        advance();
        s_ack_i = 1'b1;
        sample(); chk("w_ack", 64'(m0_ack_o), 64'h1); chk("w_m1ack", 64'(m1_ack_o), 64'h0); advance();
        idle_inputs();
        sample(); advance();
        sample(); advance();

        // m1 burst of four reads while m0 keeps requesting.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 22'h000200;
        sample(); advance();
        for (int i = 1; i <= 4; i++) begin
            s_ack_i = 1'b0;
            sample(); advance();
            s_ack_i = 1'b1; s_dat_i = DATA_W'(i);
            sample();
            chk("b_ack", 64'(m1_ack_o), 64'h1);
            chk("b_dat", 64'(m1_dat_o), 64'(i));
            chk("b_m0ack", 64'(m0_ack_o), 64'h0);
            chk("b_grant", 64'(grant_o), 64'h2);
            advance();
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        sample(); advance();
        sample(); advance();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        sample(); advance();
        sample(); advance();

        // m0 abandons after 3 stalled cycles: no error, counter starts fresh afterwards.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        sample(); advance();
        repeat (3) begin sample(); advance(); end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        sample(); chk("d_noerr", 64'(m0_err_o), 64'h0); advance();
        sample(); chk("d_idle", 64'(grant_o), 64'h0); advance();

        // Timeout: error on the 8th stalled cycle, then m1 wins contention.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        sample(); advance();
        for (int i = 1; i <= TIMEOUT; i++) begin
            sample();
            chk("t_err", 64'(m0_err_o), 64'(i == TIMEOUT));
            chk("t_cyc", 64'(s_cyc_o), 64'(i != TIMEOUT));
            advance();
        end
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        sample(); advance();
        sample(); chk("t_next", 64'(grant_o), 64'h2); advance();

        // Asynchronous reset in the middle of an m1 beat.
        s_ack_i = 1'b1;
        rst_n_i = 1'b0;
        model_reset();
        sample();
        chk("r_cyc", 64'(s_cyc_o), 64'h0);
        chk("r_grant", 64'(grant_o), 64'h0);
        chk("r_ack", 64'(m1_ack_o), 64'h0);
        advance();
        sample(); chk("r_ack2", 64'(m1_ack_o), 64'h0); advance();
        rst_n_i = 1'b1;
        idle_inputs();
        sample(); advance();

        // Random traffic; the second half starves acks to provoke timeouts.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 7) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i  = ($urandom_range(0, 3) != 0);
            m1_stb_i  = ($urandom_range(0, 3) != 0);
            m0_we_i   = $urandom_range(0, 1) == 1;
            m1_we_i   = $urandom_range(0, 1) == 1;
            m0_addr_i = ADDR_W'($urandom);
            m1_addr_i = ADDR_W'($urandom);
            m0_dat_i  = DATA_W'($urandom);
            m1_dat_i  = DATA_W'($urandom);
            s_dat_i   = DATA_W'($urandom);
            s_ack_i   = (n < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_wb_arbiter.md
SDRAM_WB_ARBITER -- requirements
Module: sdram_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 32, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max wait cycles for ack before abort (range 2..65535).
REQ-004 SHALL have port clk_i  in  1  single clock for all logic; drives master and slave sides.
REQ-005 SHALL have port rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports m0_addr_i/m1_addr_i  in  ADDR_W  master address.
REQ-007 SHALL have ports m0_dat_i/m1_dat_i  in  DATA_W  master write data.
REQ-008 SHALL have ports m0_we_i/m1_we_i, m0_stb_i/m1_stb_i, m0_cyc_i/m1_cyc_i  in  1 each  Wishbone controls.
REQ-009 SHALL have ports m0_dat_o/m1_dat_o  out  DATA_W  read data, both driven from s_dat_i.
REQ-010 SHALL have ports m0_ack_o/m1_ack_o, m0_err_o/m1_err_o  out  1 each  acknowledge / timeout error.
REQ-011 SHALL have ports s_addr_o  out  ADDR_W, s_dat_o  out  DATA_W, s_we_o/s_stb_o/s_cyc_o  out  1 each  slave side toward sdram_controller.
REQ-012 SHALL have ports s_dat_i  in  DATA_W, s_ack_i  in  1  slave read data and ack.
REQ-013 SHALL have port grant_o  out  2  one-hot current owner (01=m0, 10=m1, 00=none).

Function
REQ-014 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-015 In IDLE, only m0_cyc_i high SHALL go to GRANT0 next cycle; only m1_cyc_i high -> GRANT1.
REQ-016 In IDLE with both cyc high, SHALL grant the master not granted last (register last_grant, reset 1, so m0 wins first).
REQ-017 In IDLE, all s_* controls, acks and errs SHALL be 0; grant latency from cyc to s_cyc_o is exactly 1 cycle.
REQ-018 In GRANTx, s_addr_o/s_dat_o/s_we_o/s_stb_o/s_cyc_o SHALL combinationally follow master x.
REQ-019 In GRANTx, s_ack_i SHALL route combinationally to mx_ack_o only; the other master's ack SHALL be 0.
REQ-020 Grant SHALL be held across multiple stb/ack beats while mx_cyc_i stays high (no preemption).
REQ-021 mx_cyc_i low in GRANTx SHALL go to IDLE next cycle, even if no ack was received; ack coincident with cyc drop SHALL still reach mx_ack_o.
REQ-022 Every release SHALL pass through one IDLE cycle before the next grant.
REQ-023 Watchdog counter (16 bit) SHALL increment each GRANTx cycle with stb high and s_ack_i low, and clear on ack, on IDLE, or with stb low.
REQ-024 Counter reaching TIMEOUT SHALL pulse mx_err_o for 1 cycle, force s_cyc_o/s_stb_o to 0 that cycle, and go to IDLE.
REQ-025 After a timeout abort, last_grant SHALL equal the aborted master, so the other master wins the next contention.
REQ-026 grant_o SHALL be a registered reflection of state.

Reset
REQ-027 rst_n_i low SHALL asynchronously force state IDLE, last_grant=1, counter=0, grant_o=00; all ack/err/s_cyc_o/s_stb_o/s_we_o outputs 0.
REQ-028 Reset mid-transaction SHALL drop s_cyc_o immediately; no ack SHALL be forwarded until a new grant.

Structure
REQ-029 Shared package sdram_arb_pkg SHALL hold state encoding, grant one-hot constants, and watchdog counter width.
REQ-030 Watchdog SHALL be a sub-module sdram_arb_watchdog (inputs en, clr; output expired).

Verification
REQ-031 m0 alone: write addr 0x000010, data 0xDEADBEEF -> s_cyc_o high 1 cycle after m0_cyc_i, s_addr_o=0x000010, m0_ack_o on s_ack_i, m1_ack_o stays 0.
REQ-032 Both cyc high same cycle from reset -> grant_o=01; m0 finishes, one IDLE cycle, then grant_o=10; repeat contention -> 01 again.
REQ-033 m1 holds cyc for 4 read beats with s_dat_i 0x1..0x4 -> four m1_ack_o pulses, m1_dat_o sequence 1,2,3,4, m0 requesting throughout stays ungranted.
REQ-034 TIMEOUT=8, m0 stb with s_ack_i held 0 -> m0_err_o pulses exactly on the 8th stalled cycle, s_cyc_o 0, next contention grants m1.
REQ-035 rst_n_i pulsed low mid-beat in GRANT1 -> s_cyc_o 0 asynchronously, grant_o=00, late s_ack_i not forwarded to m1_ack_o.
REQ-036 m0 drops cyc without ack after 3 cycles -> IDLE next cycle, counter cleared, no err_o.
